// File: rtl/rr_grant_arbiter4_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) drives the grant.
interface rr_grant_arbiter4_if;
  logic [3:0] req;
  logic       release_i;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  modport master (
    output req, release_i,
    input  gnt, gnt_valid, gnt_idx, timeout
  );

  modport slave (
    input  req, release_i,
    output gnt, gnt_valid, gnt_idx, timeout
  );
endinterface

// File: rtl/rr_grant_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index
// and a hold-time watchdog that revokes a grant held for MAX_HOLD+1 cycles.
module rr_grant_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_grant_arbiter4_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         idx_q;
  logic [3:0]         gnt_q;
  logic               vld_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [1:0]         pick_idx_d;
  logic               pick_hit_d;
  logic               rel_d;
  logic               expire_d;

  // First requester at or after the pointer, wrapping 3 -> 0; bit 2 flags a hit.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] k;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = p + i[1:0];
      if (r[k]) rr_pick = {1'b1, k};
    end
  endfunction

  always_comb begin
    {pick_hit_d, pick_idx_d} = rr_pick(bus.req, ptr_q);
    rel_d    = bus.release_i | ~bus.req[idx_q];
    expire_d = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_hit_d) begin
            gnt_q   <= 4'b0001 << pick_idx_d;
            idx_q   <= pick_idx_d;
            vld_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // A release outranks the watchdog, so timeout only fires without one.
          if (rel_d || expire_d) begin
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            vld_q     <= 1'b0;
            ptr_q     <= idx_q + 2'd1;
            timeout_q <= ~rel_d;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Bench for rr_grant_arbiter4: directed grant/release sequences checked through
// an event scoreboard, followed by a randomized run against a behavioural model.
module tb_rr_grant_arbiter4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_grant_arbiter4_if bus();

  rr_grant_arbiter4 #(.MAX_HOLD(15), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       is_grant;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        e;
  int         checks = 0;
  int         passes = 0;
  logic       sb_en  = 1'b0;
  logic [3:0] mon_prev = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_ok(input string name, input bit ok, input int act, input int lim);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, limit %0d", name, act, lim);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input logic [3:0] g, input logic [1:0] idx);
    ev_t x;
    x.is_grant = 1'b1; x.gnt = g; x.idx = idx; x.to = 1'b0;
    exp_q.push_back(x);
  endtask

  task automatic push_e(input logic to);
    ev_t x;
    x.is_grant = 1'b0; x.gnt = 4'b0000; x.idx = 2'd0; x.to = to;
    exp_q.push_back(x);
  endtask

  function automatic int oh2i(input logic [3:0] g);
    case (g)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit inv_ok(input logic [3:0] g, input logic [1:0] idx, input logic v);
    case (g)
      4'b0000: return (idx == 2'd0) && !v;
      4'b0001: return (idx == 2'd0) && v;
      4'b0010: return (idx == 2'd1) && v;
      4'b0100: return (idx == 2'd2) && v;
      4'b1000: return (idx == 2'd3) && v;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard monitor: every grant start and grant end pops one expected event.
  always @(negedge clk) begin
    if (sb_en) begin
      if (mon_prev == 4'b0000 && bus.gnt != 4'b0000) begin
        if (exp_q.size() == 0) chk("sb_unexpected_grant", bus.gnt, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_kind_grant", e.is_grant, 32'd1);
          chk("sb_gnt", bus.gnt, e.gnt);
          chk("sb_idx", bus.gnt_idx, e.idx);
          chk("sb_valid", bus.gnt_valid, 32'd1);
        end
      end else if (mon_prev != 4'b0000 && bus.gnt == 4'b0000) begin
        if (exp_q.size() == 0) chk("sb_unexpected_end", mon_prev, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_kind_end", e.is_grant, 32'd0);
          chk("sb_timeout", bus.timeout, e.to);
          chk("sb_end_valid", bus.gnt_valid, 32'd0);
          chk("sb_end_idx", bus.gnt_idx, 32'd0);
        end
      end else if (mon_prev != 4'b0000 && bus.gnt != mon_prev) begin
        chk("sb_idle_gap", bus.gnt, 32'd0);
      end
    end
    mon_prev <= bus.gnt;
  end

  initial begin
    logic [3:0] r, exp_g, prev_g, prev_act;
    logic       rel, exp_to;
    int         hold, ptr_m, pidx, w, maxw;
    int         waitc[4];

    bus.req = 4'b0000;
    bus.release_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_gnt", bus.gnt, 32'd0);
    chk("rst_valid", bus.gnt_valid, 32'd0);
    chk("rst_idx", bus.gnt_idx, 32'd0);
    chk("rst_timeout", bus.timeout, 32'd0);
    sb_en = 1'b1;

    // Reset mid-grant
    bus.req = 4'b0100; push_g(4'b0100, 2'd2); step();
    chk("mid_gnt", bus.gnt, 32'h4);
    rst = 1'b1; push_e(1'b0); step();
    rst = 1'b0;
    chk("mid_rst_gnt", bus.gnt, 32'd0);
    chk("mid_rst_valid", bus.gnt_valid, 32'd0);
    chk("mid_rst_idx", bus.gnt_idx, 32'd0);
    chk("mid_rst_timeout", bus.timeout, 32'd0);
    bus.req = 4'b1111; push_g(4'b0001, 2'd0); step();
    chk("post_rst_gnt", bus.gnt, 32'h1);
    bus.release_i = 1'b1; push_e(1'b0); step();
    bus.release_i = 1'b0;

    // Single requester, pointer now 1
    bus.req = 4'b0010; push_g(4'b0010, 2'd1); step();
    chk("single_gnt", bus.gnt, 32'h2);
    chk("single_idx", bus.gnt_idx, 32'd1);
    chk("single_valid", bus.gnt_valid, 32'd1);
    step();
    bus.release_i = 1'b1; push_e(1'b0); step();
    bus.release_i = 1'b0;
    chk("single_idle", bus.gnt, 32'd0);
    push_g(4'b0010, 2'd1); step();
    chk("single_regrant", bus.gnt, 32'h2);
    bus.req = 4'b0000; push_e(1'b0); step();
    chk("single_drop", bus.gnt, 32'd0);

    // Round-robin rotation from pointer 0
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_g(4'b0001 << (k % 4), 2'(k % 4)); step();
      chk("rr_gnt", bus.gnt, 32'(4'b0001 << (k % 4)));
      chk("rr_idx", bus.gnt_idx, 32'(k % 4));
      step();
      bus.release_i = 1'b1; push_e(1'b0); step();
      bus.release_i = 1'b0;
      chk("rr_idle", bus.gnt, 32'd0);
    end

    // Request drop acts as release; pointer 1 -> grant 3 -> pointer 0
    bus.req = 4'b1000; push_g(4'b1000, 2'd3); step();
    chk("drop_gnt", bus.gnt, 32'h8);
    bus.req = 4'b0000; push_e(1'b0); step();
    chk("drop_idle", bus.gnt, 32'd0);
    bus.req = 4'b1001; push_g(4'b0001, 2'd0); step();
    chk("drop_ptr0", bus.gnt, 32'h1);
    bus.release_i = 1'b1; push_e(1'b0); step();
    bus.release_i = 1'b0; bus.req = 4'b0000;

    // release_i in IDLE is ignored (pointer 1)
    bus.release_i = 1'b1; step();
    chk("idle_rel_gnt", bus.gnt, 32'd0);
    bus.req = 4'b0010; push_g(4'b0010, 2'd1); step();
    chk("idle_rel_grant", bus.gnt, 32'h2);
    push_e(1'b0); step();
    bus.release_i = 1'b0; bus.req = 4'b0000;

    // Watchdog: 16-cycle hold, then timeout pulse, then regrant
    bus.req = 4'b0100;
    push_g(4'b0100, 2'd2); push_e(1'b1); push_g(4'b0100, 2'd2);
    step();
    hold = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.gnt == 4'b0100) hold++;
      else break;
    end
    chk("wd_hold_cycles", hold, 32'd16);
    chk("wd_gnt", bus.gnt, 32'd0);
    chk("wd_timeout", bus.timeout, 32'd1);
    step();
    chk("wd_regrant", bus.gnt, 32'h4);
    chk("wd_timeout_once", bus.timeout, 32'd0);
    for (int i = 0; i < 15; i++) step();
    chk("wd_held_15", bus.gnt, 32'h4);
    bus.release_i = 1'b1; push_e(1'b0); step();
    chk("wd_rel_gnt", bus.gnt, 32'd0);
    chk("wd_rel_wins", bus.timeout, 32'd0);
    bus.release_i = 1'b0; bus.req = 4'b0000; step();
    chk("wd_rel_after", bus.timeout, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("sb_drain", exp_q.size(), 32'd0);
    sb_en = 1'b0;

    // Randomized run against a behavioural model
    rst = 1'b1; step(); rst = 1'b0;
    r = 4'b0000; prev_g = 4'b0000; prev_act = 4'b0000;
    hold = 0; ptr_m = 0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 15) == 0);
      bus.req = r; bus.release_i = rel;
      step();
      exp_g = 4'b0000; exp_to = 1'b0;
      if (prev_g != 4'b0000) begin
        pidx = oh2i(prev_g);
        if (rel || !r[pidx]) ptr_m = (pidx + 1) % 4;
        else if (hold == 16) begin exp_to = 1'b1; ptr_m = (pidx + 1) % 4; end
        else exp_g = prev_g;
      end else begin
        for (int k = 0; k < 4; k++)
          if (exp_g == 4'b0000 && r[(ptr_m + k) % 4]) exp_g = 4'b0001 << ((ptr_m + k) % 4);
      end
      chk("rnd_gnt", bus.gnt, exp_g);
      chk("rnd_timeout", bus.timeout, exp_to);
      chk_ok("rnd_invariant", inv_ok(bus.gnt, bus.gnt_idx, bus.gnt_valid), int'(bus.gnt), 0);
      hold = (exp_g == 4'b0000) ? 0 : ((prev_g == 4'b0000) ? 1 : hold + 1);
      prev_g = exp_g;
      for (int i = 0; i < 4; i++) if (!r[i]) waitc[i] = 0;
      if (prev_act == 4'b0000 && bus.gnt != 4'b0000) begin
        w = oh2i(bus.gnt);
        maxw = 0;
        for (int i = 0; i < 4; i++) begin
          if (i == w) waitc[i] = 0;
          else if (r[i]) waitc[i]++;
          if (waitc[i] > maxw) maxw = waitc[i];
        end
        chk_ok("rnd_fair", maxw <= 3, maxw, 3);
      end
      prev_act = bus.gnt;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter4.md
Name: rr_grant_arbiter4

Overview:
- 4-requester round-robin arbiter.
- Produces a registered one-hot grant vector `gnt[3:0]` that feeds directly into the 4-to-2 encoder stage.
- Also provides its own encoded index, a valid flag, and a hold-timeout watchdog.
- Guarantees that `gnt` is always exactly one-hot or all-zero, so the downstream encoder never sees an undefined input pattern.

Parameters:
- MAX_HOLD, 15, maximum number of cycles a grant may be held before it is forcibly revoked; 0 disables the timeout.
- CNT_W, 4, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i]=1 means requester i wants the resource; level-sensitive.
- release_i  input  1  one-cycle pulse from the current owner ending its grant.
- gnt  output  4  registered one-hot grant, or 4'b0000 when idle.
- gnt_valid  output  1  1 when gnt is non-zero; equals the OR of gnt.
- gnt_idx  output  2  binary index of the granted requester; 2'b00 when idle.
- timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, hold counter=0, state=IDLE.
  - Priority pointer = 0, so req[0] has highest priority.
  - Reset overrides everything, including a grant in progress; gnt drops on the same edge.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at the edge: select the first set bit scanning ptr, ptr+1, ... with wrap 3->0.
  - Load gnt, gnt_idx, gnt_valid=1; clear the counter; go to GRANT.
  - Latency: req sampled at edge N, grant visible after edge N (one registered stage).
  - If req==0: stay in IDLE with outputs zero.
- GRANT:
  - A release condition is release_i=1 OR req[gnt_idx]=0 at the edge.
  - On a release condition: gnt=0, gnt_valid=0, gnt_idx=0, ptr=gnt_idx+1 (mod 4), go to IDLE.
  - There is always exactly one idle cycle between consecutive grants.
  - Timeout: if MAX_HOLD!=0, the counter equals MAX_HOLD, and there is no release condition:
    - Revoke exactly as for a release (ptr advances past the owner).
    - Assert timeout=1 for that one following cycle.
  - Otherwise the counter increments by 1 each cycle; it never wraps, since it is bounded by MAX_HOLD.
  - Release and timeout in the same cycle: release wins, timeout stays 0.
  - release_i while in IDLE is ignored.
  - Changes on non-owner req bits during GRANT are ignored; there is no preemption.
- Invariants:
  - gnt is one-hot or zero at all times.
  - gnt_idx is consistent with gnt (0001->0, 0010->1, 0100->2, 1000->3).
  - gnt_valid == |gnt.
- Fairness: with all 4 requesting continuously, grants cycle 0,1,2,3,0...; each requester is served within 4 grant slots.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset mid-grant:
  - Hold req=4'b0100 until gnt=4'b0100, then assert rst for 1 cycle.
  - The next cycle shows gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
  - With rst low and req=4'b1111, the next grant is 4'b0001.
- Single requester:
  - req=4'b0010 from cycle 1.
  - gnt=4'b0010, gnt_idx=2'b01, gnt_valid=1 after the next edge.
  - Pulsing release_i gives gnt=0 for one cycle, then gnt=4'b0010 again.
- Round-robin rotation:
  - req=4'b1111 held; release_i pulsed every 3rd cycle of each grant.
  - Grant sequence is 0001, 0010, 0100, 1000, 0001, separated by single idle cycles.
  - gnt_idx follows 0, 1, 2, 3, 0.
- Request drop as release:
  - Grant to req[3]; deassert req[3] with release_i=0.
  - gnt goes to 0 next edge, ptr=0.
  - With req=4'b1001, the next grant is 4'b0001.
- Watchdog:
  - MAX_HOLD=15; req=4'b0100 held, no release.
  - The grant lasts exactly 16 cycles, then gnt=0 with timeout=1 for 1 cycle.
  - Regrant 4'b0100 follows after the idle cycle.
  - Repeat with release_i asserted on the counter==15 cycle: timeout stays 0.
- Invariant check:
  - Random req and release_i for 10,000 cycles with a scoreboard model.
  - Assert gnt is one-hot or zero, gnt_idx matches gnt, and no requester waits more than 4 grants while continuously requesting.
